// File: rtl/tribus_pkg.sv
// ---------------------------------------------------------------------------
// tribus_pkg
// Shared types and parameter limits for the tristate bus arbiter.
//   tribus_state_t : arbiter FSM state (IDLE, GRANT, TURN), 2-bit encoded
//   N_REQ_MAX      : largest supported requester count
//   TURN_CYC_MAX   : largest supported turnaround gap, in cycles
//   MAX_HOLD_MAX   : largest supported tenure limit, in cycles
// ---------------------------------------------------------------------------
package tribus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } tribus_state_t;

    localparam int N_REQ_MAX    = 16;
    localparam int TURN_CYC_MAX = 7;
    localparam int MAX_HOLD_MAX = 255;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. The search starts at rr_ptr
// and wraps modulo N_REQ; the first asserted request bit wins.
// Ports:
//   req     in  [N_REQ-1:0]  request vector
//   rr_ptr  in  [IDX_W-1:0]  highest-priority index for this search
//   win_oh  out [N_REQ-1:0]  one-hot winner (zero when no request)
//   win_idx out [IDX_W-1:0]  binary index of the winner
//   valid   out              at least one request was found
// ---------------------------------------------------------------------------
module rr_pick
    import tribus_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             valid
);

    int idx;

    // NOTE: every variable written here gets a default before the loop; a
    // path that skips an assignment would otherwise infer a latch.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        valid   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!valid && req[idx]) begin
                valid       = 1'b1;
                win_idx     = IDX_W'(idx);
                win_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// ---------------------------------------------------------------------------
// tribus_arbiter
// Round-robin arbiter driving the ENB pins of N_REQ tristate drivers on one
// shared net. At most one driver is enabled, every change of owner passes
// through TURN_CYC all-off cycles, and a tenure is cut after MAX_HOLD cycles.
// Ports:
//   clk       in              rising-edge clock
//   rst       in              synchronous reset, active-high
//   req       in  [N_REQ-1:0] level requests, held until done
//   gnt       out [N_REQ-1:0] one-hot grant
//   enb       out [N_REQ-1:0] driver enables, identical to gnt
//   busy      out             arbiter in GRANT or TURN
//   tmo       out             one-cycle pulse when a tenure hits MAX_HOLD
//   keep_enb  out             bus keeper enable while no driver is on
// Build option:
//   TRIBUS_KEEPER_EN  defined   -> keep_enb is a registered "no driver" flag
//                     undefined -> keep_enb tied low, no keeper logic
// ---------------------------------------------------------------------------
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] enb,
    output logic             busy,
    output logic             tmo,
    output logic             keep_enb
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TURN_W = $clog2(TURN_CYC + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC);

    if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("tribus_arbiter: N_REQ out of range");
    end
    if (TURN_CYC < 1 || TURN_CYC > TURN_CYC_MAX) begin : g_bad_turn_cyc
        $error("tribus_arbiter: TURN_CYC out of range");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_max_hold
        $error("tribus_arbiter: MAX_HOLD out of range");
    end

    tribus_state_t     state_q,  state_d;
    logic [IDX_W-1:0]  owner_q,  owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic [TURN_W-1:0] turn_q,   turn_d;
    logic [N_REQ-1:0]  gnt_q,    gnt_d;
    logic              busy_q,   busy_d;
    logic              tmo_q,    tmo_d;

    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .valid   (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        turn_d   = turn_q;
        gnt_d    = gnt_q;
        tmo_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    gnt_d   = pick_oh;
                    hold_d  = HOLD_W'(1);
                end
            end

            GRANT: begin
                if (!req[owner_q] || hold_q == HOLD_LAST) begin
                    // A released request wins over a simultaneous timeout,
                    // so tmo only flags tenures that were actually cut.
                    tmo_d    = req[owner_q];
                    state_d  = TURN;
                    gnt_d    = '0;
                    hold_d   = '0;
                    turn_d   = TURN_W'(1);
                    rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            TURN: begin
                if (turn_q == TURN_LAST) begin
                    turn_d = '0;
                    if (pick_valid) begin
                        state_d = GRANT;
                        owner_d = pick_idx;
                        gnt_d   = pick_oh;
                        hold_d  = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_d = turn_q + TURN_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            turn_q   <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            turn_q   <= turn_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
        end
    end

    // Driver enables come from the same register as the grant, so the two
    // can never disagree.
    assign gnt  = gnt_q;
    assign enb  = gnt_q;
    assign busy = busy_q;
    assign tmo  = tmo_q;

`ifdef TRIBUS_KEEPER_EN
    logic keep_q;

    // Computed from the next grant so the keeper releases on the same edge
    // the driver turns on, and re-engages on the edge it turns off.
    always_ff @(posedge clk) begin
        if (rst) begin
            keep_q <= 1'b1;
        end else begin
            keep_q <= (gnt_d == '0);
        end
    end

    assign keep_enb = keep_q;
`else
    assign keep_enb = 1'b0;
`endif

endmodule

// File: tb/tb_tribus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tribus_arbiter
// Self-checking bench for tribus_arbiter (N_REQ=4, TURN_CYC=1, MAX_HOLD=16).
// A cycle-level reference model tracks owner, pointer, tenure length and the
// remaining dead gap as plain integers and is compared against every output
// after every clock edge, followed by directed and random stimulus.
// ---------------------------------------------------------------------------
module tb_tribus_arbiter;

    localparam int N  = 4;
    localparam int TC = 1;
    localparam int MH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] enb;
    logic         busy;
    logic         tmo;
    logic         keep_enb;

    always #5 clk = ~clk;

    tribus_arbiter #(
        .N_REQ    (N),
        .TURN_CYC (TC),
        .MAX_HOLD (MH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .enb      (enb),
        .busy     (busy),
        .tmo      (tmo),
        .keep_enb (keep_enb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 = none), next search start, cycles
    // owned so far, dead cycles still to elapse before the next arbitration.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_gap   = 0;
    bit m_tmo   = 1'b0;

    logic [N-1:0] prev_enb = '0;
    int           zero_run = 0;
    int           starts[$];
    int           gaps[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_winner(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit r_rst, input logic [N-1:0] r_req);
        int w;
        m_tmo = 1'b0;
        if (r_rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_gap   = 0;
        end else if (m_owner >= 0) begin
            if (!r_req[m_owner] || m_hold == MH) begin
                m_tmo   = r_req[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = TC;
            end else begin
                m_hold++;
            end
        end else begin
            if (m_gap > 0) m_gap--;
            if (m_gap == 0) begin
                w = rr_winner(r_req, m_ptr);
                if (w >= 0) begin
                    m_owner = w;
                    m_hold  = 1;
                end
            end
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare every output 1 time unit later.
    task automatic step();
        logic [N-1:0] exp_gnt;
        bit           exp_keep;
        @(posedge clk);
        model_edge(rst, req);
        #1;
        exp_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
`ifdef TRIBUS_KEEPER_EN
        exp_keep = (m_owner < 0);
`else
        exp_keep = 1'b0;
`endif
        check("gnt",       32'(gnt),  32'(exp_gnt));
        check("enb",       32'(enb),  32'(exp_gnt));
        check("busy",      32'(busy), 32'(m_owner >= 0 || m_gap > 0));
        check("tmo",       32'(tmo),  32'(m_tmo));
        check("keep_enb",  32'(keep_enb), 32'(exp_keep));
        check("enb_onehot0", 32'($onehot0(enb)), 32'd1);
        check("enb_no_direct_switch",
              32'(prev_enb != '0 && enb != '0 && prev_enb != enb), 32'd0);
        if (enb == '0) begin
            zero_run++;
        end else begin
            if (prev_enb == '0) begin
                for (int i = 0; i < N; i++) if (enb[i]) starts.push_back(i);
                gaps.push_back(zero_run);
            end
            zero_run = 0;
        end
        prev_enb = enb;
    endtask

    task automatic drain_to_idle();
        int budget;
        req    = '0;
        budget = 0;
        while ((m_owner >= 0 || m_gap > 0) && budget < 40) begin
            step();
            budget++;
        end
        check("drain_budget", 32'(budget < 40), 32'd1);
    endtask

    initial begin
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] raise_mask;
        int cnt;

        // Reset held two cycles with every request up.
        rst = 1'b1;
        req = 4'b1111;
        step();
        step();
        check("reset_gnt",  32'(gnt),  32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Round robin: each owner releases after 3 grant cycles and
        // re-raises one cycle later.
        starts.delete();
        gaps.delete();
        rst = 1'b0;
        step();
        check("release_gnt", 32'(gnt), 32'b0001);
        raise_mask = '0;
        cnt = 0;
        while (starts.size() < 5 && cnt < 60) begin
            req        = req | raise_mask;
            raise_mask = '0;
            if (m_owner >= 0 && m_hold == 3) begin
                req[m_owner] = 1'b0;
                raise_mask   = N'(1 << m_owner);
            end
            step();
            cnt++;
        end
        check("rr_grant_count", 32'(starts.size()), 32'd5);
        for (int i = 0; i < 5 && i < starts.size(); i++) begin
            check("rr_owner", 32'(starts[i]), 32'(exp_seq[i]));
            if (i > 0) check("rr_gap", 32'(gaps[i]), 32'(TC));
        end

        // Timeout: requester 2 holds alone past MAX_HOLD.
        drain_to_idle();
        req = 4'b0100;
        step();
        cnt = 0;
        while (enb == 4'b0100 && cnt < 40) begin
            cnt++;
            step();
        end
        check("tmo_hold_len", 32'(cnt), 32'(MH));
        check("tmo_pulse",    32'(tmo), 32'd1);
        check("tmo_gap_enb",  32'(enb), 32'd0);
        step();
        check("tmo_regrant",  32'(enb), 32'b0100);
        check("tmo_cleared",  32'(tmo), 32'd0);

        // Mid-tenure reset with the pointer parked on requester 2.
        drain_to_idle();
        req = 4'b0010;
        step();
        step();
        req = 4'b0000;
        step();
        step();
        req = 4'b0010;
        step();
        check("mid_pre_gnt", 32'(gnt), 32'b0010);
        step();
        rst = 1'b1;
        step();
        check("mid_rst_enb",  32'(enb),  32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        req = 4'b0110;
        step();
        check("mid_post_gnt", 32'(gnt), 32'b0010);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        drain_to_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
